// File: rtl/pipeline_mem_pkg.sv
// Shared constants, state encoding and size helper for the
// pipeline memory stage.
package pipeline_mem_pkg;

    localparam logic [6:0] OP_NOP   = 7'd0;
    localparam logic [6:0] OP_LOAD  = 7'd1;
    localparam logic [6:0] OP_STORE = 7'd2;
    localparam logic [6:0] OP_ALU   = 7'd3;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT
    } state_e;

    function automatic logic [3:0] lane_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/pipeline_mem_stage_lsu_align.sv
// Byte-lane alignment: load extract/extend and store shift/strobe.
// Purely combinational.
module mem_lane_align
    import pipeline_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int OFF_W      = $clog2(DATA_WIDTH / 8),
    parameter int STRB_W     = DATA_WIDTH / 8
) (
    input  logic [OFF_W-1:0]      offset,
    input  logic [2:0]            size,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] load_val,
    output logic [DATA_WIDTH-1:0] store_data,
    output logic [STRB_W-1:0]     store_strb
);

    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] mask;
    logic                  sign;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        mask    = '1;
        sign    = shifted[DATA_WIDTH-1];
        case (size[1:0])
            SZ_B: begin
                mask = DATA_WIDTH'(8'hFF);
                sign = shifted[7];
            end
            SZ_H: begin
                mask = DATA_WIDTH'(16'hFFFF);
                sign = shifted[15];
            end
            SZ_W: begin
                mask = DATA_WIDTH'(32'hFFFF_FFFF);
                sign = shifted[31];
            end
            default: ;
        endcase
        // Full-width lanes have an empty ~mask, so extension is a no-op.
        load_val = shifted & mask;
        if (!size[2] && sign) begin
            load_val = load_val | ~mask;
        end
        store_data = wdata << {offset, 3'b000};
        store_strb = STRB_W'((9'd1 << lane_bytes(size[1:0])) - 9'd1) << offset;
    end

endmodule

// File: rtl/pipeline_mem_stage_lsu.sv
// Memory stage: registers requests, runs the load/store bus handshakes,
// flags misalignment and bus timeouts, emits a one-cycle writeback.
module pipeline_mem_stage_lsu
    import pipeline_mem_pkg::*;
#(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    ready,
    input  logic [DATA_WIDTH-1:0]   ex_res,
    input  logic [DATA_WIDTH-1:0]   r2_val,
    input  logic [4:0]              dst_reg,
    input  logic [6:0]              opcode,
    input  logic [3:0]              mem_operation_size,
    input  logic                    ecall,
    output logic                    wb_enable,
    output logic [4:0]              wb_dst_reg,
    output logic [DATA_WIDTH-1:0]   wb_dst_val,
    output logic                    ecall_wb,
    output logic                    misaligned,
    output logic                    bus_err,
    output logic [ADDR_WIDTH-1:0]   S_R_ADDR,
    output logic                    S_R_ADDR_VALID,
    input  logic [DATA_WIDTH-1:0]   S_R_DATA,
    input  logic                    S_R_DATA_VALID,
    output logic                    S_W_VALID,
    output logic [ADDR_WIDTH-1:0]   S_W_ADDR,
    output logic [DATA_WIDTH-1:0]   S_W_DATA,
    output logic [DATA_WIDTH/8-1:0] S_W_STRB,
    input  logic                    S_W_READY,
    input  logic                    S_W_COMPLETE
);

    localparam int OFF_W  = $clog2(DATA_WIDTH / 8);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] T_LIM = CW'(TIMEOUT_CYCLES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRB_W - 1);

    state_e state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            size_q, size_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [4:0]            dst_q, dst_d;
    logic                  ecall_q, ecall_d;

    logic                  wb_enable_q, wb_enable_d;
    logic [4:0]            wb_dst_reg_q, wb_dst_reg_d;
    logic [DATA_WIDTH-1:0] wb_dst_val_q, wb_dst_val_d;
    logic                  ecall_wb_q, ecall_wb_d;
    logic                  misaligned_q, misaligned_d;
    logic                  bus_err_q, bus_err_d;
    logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
    logic                  r_valid_q, r_valid_d;
    logic                  w_valid_q, w_valid_d;
    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [STRB_W-1:0]     w_strb_q, w_strb_d;

    logic [ADDR_WIDTH-1:0] addr_in;
    logic [2:0]            amask;
    logic                  mis;
    logic [CW-1:0]         cnt_inc;
    logic                  expire;
    logic [DATA_WIDTH-1:0] load_val;
    logic [DATA_WIDTH-1:0] store_data;
    logic [STRB_W-1:0]     store_strb;

    mem_lane_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_align (
        .offset    (addr_q[OFF_W-1:0]),
        .size      (size_q),
        .rdata     (S_R_DATA),
        .wdata     (wdata_q),
        .load_val  (load_val),
        .store_data(store_data),
        .store_strb(store_strb)
    );

    assign addr_in = ADDR_WIDTH'(ex_res);
    assign amask   = 3'(lane_bytes(mem_operation_size[1:0]) - 4'd1);
    assign mis     = (|(addr_in[2:0] & amask)) ||
                     (mem_operation_size[1:0] == SZ_D && DATA_WIDTH == 32);
    assign cnt_inc = cnt_q + 1'b1;
    assign expire  = (TIMEOUT_CYCLES != 0) && (cnt_inc == T_LIM);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        size_d       = size_q;
        wdata_d      = wdata_q;
        dst_d        = dst_q;
        ecall_d      = ecall_q;
        wb_enable_d  = 1'b0;
        wb_dst_reg_d = wb_dst_reg_q;
        wb_dst_val_d = wb_dst_val_q;
        ecall_wb_d   = 1'b0;
        misaligned_d = 1'b0;
        bus_err_d    = 1'b0;
        r_addr_d     = r_addr_q;
        r_valid_d    = r_valid_q;
        w_valid_d    = w_valid_q;
        w_addr_d     = w_addr_q;
        w_data_d     = w_data_q;
        w_strb_d     = w_strb_q;
        if (state_q != IDLE) begin
            cnt_d = cnt_inc;
        end
        unique case (state_q)
            IDLE: if (in_valid) begin
                addr_d  = addr_in;
                size_d  = mem_operation_size[2:0];
                wdata_d = r2_val;
                dst_d   = dst_reg;
                ecall_d = ecall;
                cnt_d   = '0;
                case (opcode)
                    OP_LOAD: if (mis) begin
                        misaligned_d = 1'b1;
                    end else begin
                        state_d   = RD_REQ;
                        r_valid_d = 1'b1;
                        r_addr_d  = addr_in & ALIGN_MASK;
                    end
                    OP_STORE: if (mis) begin
                        misaligned_d = 1'b1;
                    end else begin
                        state_d = WR_REQ;
                    end
                    OP_ALU: begin
                        wb_enable_d  = 1'b1;
                        wb_dst_reg_d = dst_reg;
                        wb_dst_val_d = ex_res;
                        ecall_wb_d   = ecall;
                    end
                    default: ecall_wb_d = ecall;
                endcase
            end
            RD_REQ: begin
                state_d = RD_WAIT;
            end
            RD_WAIT: if (S_R_DATA_VALID) begin
                state_d      = IDLE;
                r_valid_d    = 1'b0;
                wb_enable_d  = 1'b1;
                wb_dst_reg_d = dst_q;
                wb_dst_val_d = load_val;
                ecall_wb_d   = ecall_q;
            end
            WR_REQ: if (!expire && S_W_READY) begin
                state_d   = WR_WAIT;
                w_valid_d = 1'b1;
                w_addr_d  = addr_q & ALIGN_MASK;
                w_data_d  = store_data;
                w_strb_d  = store_strb;
            end
            WR_WAIT: if (S_W_COMPLETE) begin
                state_d    = IDLE;
                w_valid_d  = 1'b0;
                ecall_wb_d = ecall_q;
            end
            default: state_d = IDLE;
        endcase
        // A completion on the expiry edge has already moved us to IDLE.
        if (state_q != IDLE && state_d != IDLE && expire) begin
            state_d   = IDLE;
            r_valid_d = 1'b0;
            w_valid_d = 1'b0;
            bus_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            size_q       <= '0;
            wdata_q      <= '0;
            dst_q        <= '0;
            ecall_q      <= 1'b0;
            wb_enable_q  <= 1'b0;
            wb_dst_reg_q <= '0;
            wb_dst_val_q <= '0;
            ecall_wb_q   <= 1'b0;
            misaligned_q <= 1'b0;
            bus_err_q    <= 1'b0;
            r_addr_q     <= '0;
            r_valid_q    <= 1'b0;
            w_valid_q    <= 1'b0;
            w_addr_q     <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            wdata_q      <= wdata_d;
            dst_q        <= dst_d;
            ecall_q      <= ecall_d;
            wb_enable_q  <= wb_enable_d;
            wb_dst_reg_q <= wb_dst_reg_d;
            wb_dst_val_q <= wb_dst_val_d;
            ecall_wb_q   <= ecall_wb_d;
            misaligned_q <= misaligned_d;
            bus_err_q    <= bus_err_d;
            r_addr_q     <= r_addr_d;
            r_valid_q    <= r_valid_d;
            w_valid_q    <= w_valid_d;
            w_addr_q     <= w_addr_d;
            w_data_q     <= w_data_d;
            w_strb_q     <= w_strb_d;
        end
    end

    assign ready          = (state_q == IDLE);
    assign wb_enable      = wb_enable_q;
    assign wb_dst_reg     = wb_dst_reg_q;
    assign wb_dst_val     = wb_dst_val_q;
    assign ecall_wb       = ecall_wb_q;
    assign misaligned     = misaligned_q;
    assign bus_err        = bus_err_q;
    assign S_R_ADDR       = r_addr_q;
    assign S_R_ADDR_VALID = r_valid_q;
    assign S_W_VALID      = w_valid_q;
    assign S_W_ADDR       = w_addr_q;
    assign S_W_DATA       = w_data_q;
    assign S_W_STRB       = w_strb_q;

endmodule

// File: tb/tb_pipeline_mem_stage_lsu.sv
// Directed bench for pipeline_mem_stage_lsu with a short bus timeout.
module tb_pipeline_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        ready;
    logic [63:0] ex_res;
    logic [63:0] r2_val;
    logic [4:0]  dst_reg;
    logic [6:0]  opcode;
    logic [3:0]  mem_operation_size;
    logic        ecall;
    logic        wb_enable;
    logic [4:0]  wb_dst_reg;
    logic [63:0] wb_dst_val;
    logic        ecall_wb;
    logic        misaligned;
    logic        bus_err;
    logic [63:0] S_R_ADDR;
    logic        S_R_ADDR_VALID;
    logic [63:0] S_R_DATA;
    logic        S_R_DATA_VALID;
    logic        S_W_VALID;
    logic [63:0] S_W_ADDR;
    logic [63:0] S_W_DATA;
    logic [7:0]  S_W_STRB;
    logic        S_W_READY;
    logic        S_W_COMPLETE;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipeline_mem_stage_lsu #(
        .ADDR_WIDTH    (64),
        .DATA_WIDTH    (64),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .in_valid          (in_valid),
        .ready             (ready),
        .ex_res            (ex_res),
        .r2_val            (r2_val),
        .dst_reg           (dst_reg),
        .opcode            (opcode),
        .mem_operation_size(mem_operation_size),
        .ecall             (ecall),
        .wb_enable         (wb_enable),
        .wb_dst_reg        (wb_dst_reg),
        .wb_dst_val        (wb_dst_val),
        .ecall_wb          (ecall_wb),
        .misaligned        (misaligned),
        .bus_err           (bus_err),
        .S_R_ADDR          (S_R_ADDR),
        .S_R_ADDR_VALID    (S_R_ADDR_VALID),
        .S_R_DATA          (S_R_DATA),
        .S_R_DATA_VALID    (S_R_DATA_VALID),
        .S_W_VALID         (S_W_VALID),
        .S_W_ADDR          (S_W_ADDR),
        .S_W_DATA          (S_W_DATA),
        .S_W_STRB          (S_W_STRB),
        .S_W_READY         (S_W_READY),
        .S_W_COMPLETE      (S_W_COMPLETE)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [6:0] op, input logic [3:0] sz,
                         input logic [63:0] ex, input logic [63:0] r2,
                         input logic [4:0] dst, input logic ec);
        opcode             = op;
        mem_operation_size = sz;
        ex_res             = ex;
        r2_val             = r2;
        dst_reg            = dst;
        ecall              = ec;
        in_valid           = 1'b1;
        cyc();
        in_valid = 1'b0;
        opcode   = 7'd0;
        ecall    = 1'b0;
    endtask

    task automatic load_resp(input logic [63:0] data);
        S_R_DATA       = data;
        S_R_DATA_VALID = 1'b1;
        cyc();
        check("rd_wait_valid", S_R_ADDR_VALID, 1'b1);
        check("rd_wait_no_wb", wb_enable, 1'b0);
        cyc();
        S_R_DATA_VALID = 1'b0;
    endtask

    initial begin
        reset              = 1'b1;
        in_valid           = 1'b0;
        ex_res             = '0;
        r2_val             = '0;
        dst_reg            = '0;
        opcode             = '0;
        mem_operation_size = '0;
        ecall              = 1'b0;
        S_R_DATA           = '0;
        S_R_DATA_VALID     = 1'b0;
        S_W_READY          = 1'b0;
        S_W_COMPLETE       = 1'b0;
        cyc();
        cyc();
        check("rst_ready", ready, 1'b1);
        check("rst_wb", wb_enable, 1'b0);
        check("rst_rvalid", S_R_ADDR_VALID, 1'b0);
        check("rst_wvalid", S_W_VALID, 1'b0);
        check("rst_buserr", bus_err, 1'b0);
        reset = 1'b0;
        cyc();

        // ALU back-to-back
        opcode   = 7'd3;
        ex_res   = 64'h11;
        dst_reg  = 5'd5;
        in_valid = 1'b1;
        cyc();
        check("alu1_wb", wb_enable, 1'b1);
        check("alu1_reg", wb_dst_reg, 5'd5);
        check("alu1_val", wb_dst_val, 64'h11);
        check("alu1_ready", ready, 1'b1);
        ex_res  = 64'h22;
        dst_reg = 5'd6;
        cyc();
        in_valid = 1'b0;
        opcode   = 7'd0;
        check("alu2_wb", wb_enable, 1'b1);
        check("alu2_reg", wb_dst_reg, 5'd6);
        check("alu2_val", wb_dst_val, 64'h22);
        check("alu2_ready", ready, 1'b1);
        cyc();
        check("alu_idle_wb", wb_enable, 1'b0);

        // nop with ecall marker
        issue(7'd0, 4'd0, 64'h0, 64'h0, 5'd1, 1'b1);
        check("nop_ecall", ecall_wb, 1'b1);
        check("nop_wb", wb_enable, 1'b0);

        // signed byte load
        issue(7'd1, 4'b0000, 64'h1003, 64'h0, 5'd7, 1'b0);
        check("lb_addr", S_R_ADDR, 64'h1000);
        check("lb_rvalid", S_R_ADDR_VALID, 1'b1);
        check("lb_busy", ready, 1'b0);
        load_resp(64'h00000000_80000000);
        check("lb_wb", wb_enable, 1'b1);
        check("lb_reg", wb_dst_reg, 5'd7);
        check("lb_val", wb_dst_val, 64'hFFFFFFFF_FFFFFF80);
        check("lb_rdrop", S_R_ADDR_VALID, 1'b0);
        check("lb_ready", ready, 1'b1);

        // unsigned byte load
        issue(7'd1, 4'b0100, 64'h1003, 64'h0, 5'd8, 1'b0);
        load_resp(64'h00000000_80000000);
        check("lbu_val", wb_dst_val, 64'h80);

        // signed word load on upper lane, with ecall
        issue(7'd1, 4'b0010, 64'h1004, 64'h0, 5'd9, 1'b1);
        check("lw_addr", S_R_ADDR, 64'h1000);
        load_resp(64'h80000001_12345678);
        check("lw_val", wb_dst_val, 64'hFFFFFFFF_80000001);
        check("lw_ecall", ecall_wb, 1'b1);

        // half store, ready delayed, completion on the expiry edge
        issue(7'd2, 4'b0001, 64'h2006, 64'hBEEF, 5'd0, 1'b1);
        check("sh_wait0", S_W_VALID, 1'b0);
        cyc();
        cyc();
        check("sh_wait2", S_W_VALID, 1'b0);
        S_W_READY = 1'b1;
        cyc();
        S_W_READY = 1'b0;
        check("sh_wvalid", S_W_VALID, 1'b1);
        check("sh_addr", S_W_ADDR, 64'h2000);
        check("sh_data", S_W_DATA, 64'hBEEF0000_00000000);
        check("sh_strb", S_W_STRB, 8'hC0);
        S_W_COMPLETE = 1'b1;
        cyc();
        S_W_COMPLETE = 1'b0;
        check("sh_wdrop", S_W_VALID, 1'b0);
        check("sh_no_buserr", bus_err, 1'b0);
        check("sh_ecall", ecall_wb, 1'b1);
        check("sh_no_wb", wb_enable, 1'b0);
        check("sh_ready", ready, 1'b1);

        // misaligned word load
        issue(7'd1, 4'b0010, 64'h3002, 64'h0, 5'd3, 1'b0);
        check("mis_pulse", misaligned, 1'b1);
        check("mis_rvalid", S_R_ADDR_VALID, 1'b0);
        check("mis_wb", wb_enable, 1'b0);
        check("mis_ready", ready, 1'b1);
        cyc();
        check("mis_clear", misaligned, 1'b0);

        // timeout on a load with no response
        issue(7'd1, 4'b0011, 64'h4000, 64'h0, 5'd4, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("to_pending", bus_err, 1'b0);
        end
        check("to_rvalid_held", S_R_ADDR_VALID, 1'b1);
        cyc();
        check("to_buserr", bus_err, 1'b1);
        check("to_rdrop", S_R_ADDR_VALID, 1'b0);
        check("to_ready", ready, 1'b1);
        check("to_no_wb", wb_enable, 1'b0);
        cyc();
        check("to_pulse_end", bus_err, 1'b0);

        // reset in RD_WAIT, late data ignored
        issue(7'd1, 4'b0011, 64'h5000, 64'h0, 5'd2, 1'b0);
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("rw_rvalid", S_R_ADDR_VALID, 1'b0);
        check("rw_ready", ready, 1'b1);
        S_R_DATA       = 64'hDEAD;
        S_R_DATA_VALID = 1'b1;
        cyc();
        check("rw_late0", wb_enable, 1'b0);
        S_R_DATA_VALID = 1'b0;
        cyc();
        check("rw_late1", wb_enable, 1'b0);
        check("rw_buserr", bus_err, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_mem_stage_lsu.md
Name: pipeline_mem_stage_lsu

Overview:
Parametrised memory stage of the in-order pipeline, sitting between execute and writeback. It registers each request on acceptance, so upstream need not hold inputs. It performs sub-word loads (byte/half/word/dword, signed or unsigned) and sub-word stores with byte strobes. It also detects misalignment, enforces a bus timeout, and produces a registered single-cycle writeback pulse.

Parameters:
ADDR_WIDTH, 64, address bus width
DATA_WIDTH, 64, data bus width; power of two, 32 or 64
TIMEOUT_CYCLES, 256, wait-state limit before bus error; 0 disables the timeout

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_valid  in  1  request present
ready  out  1  stage can accept; equals (state==IDLE)
ex_res  in  DATA_WIDTH  ALU result / effective address
r2_val  in  DATA_WIDTH  store data
dst_reg  in  5  destination register
opcode  in  7  0 nop, 1 load, 2 store, 3 ALU writeback, others treated as nop
mem_operation_size  in  4  [1:0] log2 bytes (0 B, 1 H, 2 W, 3 D); [2] unsigned load; [3] ignored
ecall  in  1  ecall marker
wb_enable  out  1  one-cycle writeback pulse
wb_dst_reg  out  5  writeback register
wb_dst_val  out  DATA_WIDTH  writeback value
ecall_wb  out  1  ecall marker aligned with the result
misaligned  out  1  one-cycle pulse: access not naturally aligned
bus_err  out  1  one-cycle pulse: timeout expired
S_R_ADDR  out  ADDR_WIDTH  word-aligned read address
S_R_ADDR_VALID  out  1  read request
S_R_DATA  in  DATA_WIDTH  read data (full word)
S_R_DATA_VALID  in  1  read data valid
S_W_VALID  out  1  write request
S_W_ADDR  out  ADDR_WIDTH  word-aligned write address
S_W_DATA  out  DATA_WIDTH  lane-shifted write data
S_W_STRB  out  DATA_WIDTH/8  byte enables
S_W_READY  in  1  write channel can accept
S_W_COMPLETE  in  1  write done

Behaviour:
- Reset: state IDLE. All outputs 0, except ready=1 combinationally once in IDLE.
- Reset mid-operation: request valids drop at the reset edge. No writeback, error pulse or completion is produced for the aborted request.
- Accept: on the edge where in_valid and ready are both high, latch opcode, size, ex_res, r2_val, dst_reg and ecall.
- Nop, or an opcode outside 1..3: stay IDLE. ecall_wb still pulses one cycle later if ecall was set.
- ALU (opcode 3): wb_enable=1, wb_dst_val=ex_res and ecall_wb=ecall on the cycle after acceptance. State stays IDLE, so back-to-back accepts are allowed.
- Misalignment: the access is misaligned when the low log2(size) address bits are nonzero, or when size=3 and DATA_WIDTH=32.
  - Misaligned load or store: misaligned pulses on the cycle after acceptance.
  - No bus request is made, no writeback occurs, and the stage stays IDLE.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
- Load:
  - IDLE→RD_REQ on accept. The next cycle drives S_R_ADDR = addr with the low log2(DATA_WIDTH/8) bits cleared, and asserts S_R_ADDR_VALID.
  - RD_REQ→RD_WAIT immediately. S_R_ADDR_VALID is held until S_R_DATA_VALID is sampled high.
  - On that edge: valid drops, state→IDLE, and the next cycle has wb_enable=1.
  - wb_dst_val = the selected lane (byte offset = addr low bits), sign-extended, or zero-extended when size[2]=1.
  - A dword load on DATA_WIDTH=64 ignores size[2].
- Store:
  - IDLE→WR_REQ on accept. Wait for S_W_READY.
  - On the edge where S_W_READY is sampled high: drive the aligned S_W_ADDR, S_W_DATA = r2_val shifted left by 8×offset, and S_W_STRB = ((1<<bytes)-1)<<offset. Set S_W_VALID=1 and go to WR_WAIT.
  - In WR_WAIT, on S_W_COMPLETE: S_W_VALID drops and state→IDLE. No writeback.
- S_W_COMPLETE outside WR_WAIT and S_R_DATA_VALID outside RD_WAIT are ignored.
- Timeout:
  - A cycle counter clears on entering RD_REQ or WR_REQ and increments every cycle in RD_REQ, RD_WAIT, WR_REQ and WR_WAIT.
  - When it reaches TIMEOUT_CYCLES, request valids drop, bus_err pulses one cycle, there is no writeback, and state→IDLE.
  - If data or completion arrives on the expiry cycle, completion wins.
- ecall_wb accompanies the wb pulse for loads. For stores it pulses on the completion cycle.
- Outputs are registered except ready.

Decomposition:
- Package pipeline_mem_pkg holds:
  - opcode constants OP_NOP, OP_LOAD, OP_STORE, OP_ALU
  - size constants SZ_B, SZ_H, SZ_W, SZ_D
  - the state enum
  - function lane_bytes(size)
- One sub-module, mem_lane_align (combinational), covers both paths:
  - load extract/extend
  - store shift/strobe

Test Plan:
- ALU back-to-back: opcode 3, ex_res=0x11, dst 5, then opcode 3, ex_res=0x22, dst 6 → wb pulses on consecutive cycles with matching reg/value pairs; ready stays 1.
- Signed byte load: addr 0x1003, S_R_DATA=0x00000000_80000000, size=0 → S_R_ADDR=0x1000, wb_dst_val=0xFFFFFFFF_FFFFFF80; unsigned variant gives 0x80.
- Half store: addr 0x2006, r2_val=0xBEEF, S_W_READY delayed 3 cycles → S_W_ADDR=0x2000, S_W_DATA=0xBEEF_0000_0000_0000, S_W_STRB=0xC0; S_W_VALID held until S_W_COMPLETE.
- Misaligned word load: addr 0x3002 → misaligned pulse, no S_R_ADDR_VALID, no wb.
- Timeout: TIMEOUT_CYCLES=4, load with no S_R_DATA_VALID → bus_err after 4 wait cycles, S_R_ADDR_VALID drops, ready returns.
- Reset in RD_WAIT → next cycle all valids 0, ready=1; a late S_R_DATA_VALID produces no wb.
